uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning CLK_100MHz cycles per UART bit (115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, 2..256.
REQ-003 SHALL have port CLK_100MHz  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port load  input  1  push request for in[7:0], one word per high cycle.
REQ-006 SHALL have port in  input  16  data word; only in[7:0] transmitted, in[15:8] ignored.
REQ-007 SHALL have port TX  output  1  serial line, idle high.
REQ-008 SHALL have port tx_busy  output  1  high while FIFO non-empty or a frame is on the line.
REQ-009 SHALL have port full  output  1  high when FIFO holds DEPTH entries.
REQ-010 SHALL have port overflow  output  1  sticky flag: a push was dropped.

Function
REQ-011 SHALL frame each byte as 8N1: start bit 0, data LSB first, one stop bit 1, each bit held exactly CLKS_PER_BIT cycles.
REQ-012 SHALL accept a push when load=1 and (full=0, or full=1 with a pop in the same cycle).
REQ-013 SHALL drop a push when load=1, full=1 and no pop that cycle, and set overflow on the next edge.
REQ-014 SHALL use states IDLE, START, DATA, STOP: IDLE->START on FIFO non-empty (pop that cycle); START->DATA after CLKS_PER_BIT; DATA->STOP after 8th bit; STOP->START if FIFO non-empty at stop-bit end (back-to-back, no idle gap), else STOP->IDLE.
REQ-015 SHALL drive TX low on the cycle after the pop edge: a push into an empty idle block gives TX=0 two edges after the load edge.
REQ-016 SHALL pop only from a non-empty FIFO; push and pop on an empty FIFO cannot coincide: the word is written, then popped next cycle.
REQ-017 SHALL keep read/write pointers log2(DEPTH) bits wide, wrapping modulo DEPTH, with a count of log2(DEPTH)+1 bits deriving full/empty.
REQ-018 SHALL register TX (no combinational path from load/in to TX).
REQ-019 SHALL deassert tx_busy the cycle after the final stop bit completes with FIFO empty.

Reset
REQ-020 SHALL, while rst_n=0, force TX=1, tx_busy=0, full=0, overflow=0, state IDLE, FIFO empty, counters 0.
REQ-021 SHALL abort any frame in progress on reset assertion, with TX returning to 1 immediately (asynchronous).
REQ-022 SHALL discard FIFO contents on reset; overflow cleared only by reset.
REQ-023 SHALL release reset cleanly: first push accepted on the first rising edge with rst_n=1.

Configuration
REQ-024 SHALL honour macro UART_TX_FIFO_EN: defined -> DEPTH-entry FIFO as above; undefined -> single holding register (effective DEPTH=1, DEPTH ignored), full=1 while holding register occupied; framing, ports and reset behaviour identical in both builds.

Structure
REQ-025 SHALL take the state encoding (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT/DEPTH constants from the shared UART package used by the receiver.
REQ-026 SHALL place the FIFO in one sub-module, sync_fifo (push/pop/full/empty/count), instantiated only when UART_TX_FIFO_EN is defined.

Verification (CLKS_PER_BIT=4, DEPTH=4 unless stated)
REQ-027 SHALL check single byte: push in=16'hAB55 when idle -> TX =0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB-first, stop), 4 cycles per bit, tx_busy low after 40 bit-cycles.
REQ-028 SHALL check burst: push 0x01,0x02,0x03 on consecutive cycles -> three back-to-back frames, no idle bit between, bytes in order.
REQ-029 SHALL check overflow: push 6 bytes back-to-back while idle -> first 5 sent (1 in shifter + 4 in FIFO), 6th dropped, full=1 during push 5, overflow=1 after push 6.
REQ-030 SHALL check push-while-full-with-pop: full=1 and load coincides with a pop -> word accepted, overflow stays 0.
REQ-031 SHALL check reset mid-frame: rst_n low during DATA bit 3 -> TX=1 immediately, tx_busy=0, FIFO empty; new push after release transmits correctly.
REQ-032 SHALL check build without UART_TX_FIFO_EN: second push during frame -> held; third push before the first frame ends -> dropped, overflow=1.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: line state encoding and default timing/buffer constants.
package uart_tx_buffered_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int unsigned UART_FIFO_DEPTH   = 16;
  localparam int unsigned UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous FIFO with power-of-two depth, wrapping pointers and an occupancy count.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is still taken when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter.
// Build option UART_TX_FIFO_EN: defined -> DEPTH-entry sync_fifo ahead of the shifter;
// undefined -> single holding register (DEPTH ignored).
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DEPTH        = UART_FIFO_DEPTH
) (
  input  logic        CLK_100MHz,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] in,
  output logic        TX,
  output logic        tx_busy,
  output logic        full,
  output logic        overflow
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        overflow_q, overflow_d;

  logic        pop;
  logic        bit_done;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;

  logic        unused_in_hi;
  assign unused_in_hi = ^in[15:8];

`ifdef UART_TX_FIFO_EN
  logic [$clog2(DEPTH):0] unused_fifo_count;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLK_100MHz),
    .rst_n (rst_n),
    .push  (load),
    .pop   (pop),
    .wdata (in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );
`else
  localparam int unsigned unused_depth = DEPTH;

  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;

  // Single-entry buffer; refilled in the same cycle the shifter takes its word.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (pop) hold_valid_d = 1'b0;
    if (load && (!hold_valid_q || pop)) begin
      hold_d       = in[7:0];
      hold_valid_d = 1'b1;
    end
  end

  // Holding register flops.
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign fifo_full  = hold_valid_q;
  assign fifo_empty = !hold_valid_q;
  assign fifo_rdata = hold_q;
`endif

  // State, timing and line registers.
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state, bit timing and buffer pop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    bit_done  = (cnt_q == BIT_LAST);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    overflow_d = overflow_q | (load & fifo_full & ~pop);
  end

  // Line level is computed from the next state so TX leaves a flop.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    tx_busy = (state_q != IDLE) || !fifo_empty;
  end

  assign TX       = tx_q;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered with CLKS_PER_BIT=4, DEPTH=4 (works with or without UART_TX_FIFO_EN).
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  localparam int NLOG = 512;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] in    = '0;
  logic        TX, tx_busy, full, overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (4)
  ) dut (
    .CLK_100MHz (clk),
    .rst_n      (rst_n),
    .load       (load),
    .in         (in),
    .TX         (TX),
    .tx_busy    (tx_busy),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of waiting bytes plus the position inside the frame on the line.
  logic [7:0] mq[$];
  int         m_pos = -1;
  logic [7:0] m_cur = '0;
  logic       m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] popped;
    bit         popped_v;
    if (!rst_n) begin
      mq.delete();
      m_pos = -1;
      m_ovf = 1'b0;
    end else begin
      popped_v = 1'b0;
      popped   = '0;
      if (mq.size() != 0 && (m_pos < 0 || m_pos == FRAME - 1)) begin
        popped   = mq.pop_front();
        popped_v = 1'b1;
      end
      if (load) begin
        if (mq.size() < CAP) mq.push_back(in[7:0]);
        else m_ovf = 1'b1;
      end
      if (popped_v) begin
        m_pos = 0;
        m_cur = popped;
      end else if (m_pos == FRAME - 1) begin
        m_pos = -1;
      end else if (m_pos >= 0) begin
        m_pos++;
      end
    end
  end

  function automatic logic m_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  always @(negedge clk) begin
    chk("cyc_TX", TX, m_tx());
    chk("cyc_busy", tx_busy, (m_pos >= 0 || mq.size() != 0));
    chk("cyc_full", full, (mq.size() == CAP));
    chk("cyc_overflow", overflow, m_ovf);
  end

  // Directed stimulus with per-cycle capture; sample n is taken after the n-th rising edge.
  logic txs[NLOG];
  logic busys[NLOG];
  logic fulls[NLOG];
  logic ovfs[NLOG];

  task automatic run_seq(input logic [63:0] pmask, input logic [7:0] base, input int ncyc);
    int k = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (n < 64 && pmask[n]) begin
        load = 1'b1;
        in   = {8'hC3 ^ 8'(n), base + 8'(k)};
        k++;
      end else begin
        load = 1'b0;
        in   = '1;
      end
      @(negedge clk);
      txs[n]   = TX;
      busys[n] = tx_busy;
      fulls[n] = full;
      ovfs[n]  = overflow;
    end
    load = 1'b0;
  endtask

  function automatic logic [7:0] dec(input int s);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = txs[s + CPB * (k + 1) + CPB / 2];
    return r;
  endfunction

  function automatic int first_idle(input int lim);
    for (int n = 1; n < lim; n++) if (!busys[n]) return n;
    return -1;
  endfunction

  task automatic check_frames(input int nf, input logic [7:0] base, input string tag);
    for (int i = 0; i < nf; i++) begin
      int s;
      s = 1 + FRAME * i;
      chk({tag, "_start"}, txs[s + CPB / 2], 0);
      chk({tag, "_byte"}, dec(s), base + 8'(i));
      chk({tag, "_stop"}, txs[s + FRAME - CPB / 2], 1);
    end
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0]  exp_bits;
    logic [63:0] m;
    int          nf;
    int          ncyc;

    repeat (3) @(negedge clk);
    chk("reset_TX", TX, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_full", full, 0);
    chk("reset_overflow", overflow, 0);
    rst_n = 1'b1;

    // Single byte 0x55 with junk in the upper half of the word.
    exp_bits = 10'b1010101010;
    load = 1'b1;
    in   = 16'hAB55;
    @(negedge clk);
    load = 1'b0;
    txs[0] = TX; busys[0] = tx_busy;
    for (int n = 1; n < 60; n++) begin
      @(negedge clk);
      txs[n] = TX; busys[n] = tx_busy;
    end
    chk("single_tx_before_start", txs[0], 1);
    chk("single_busy_after_load", busys[0], 1);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < CPB; j++)
        chk("single_frame_bit", txs[1 + CPB * k + j], exp_bits[k]);
    chk("single_busy_release", first_idle(60), 41);

    // Three pushes on consecutive cycles.
    nf   = (CAP + 1 < 3) ? CAP + 1 : 3;
    ncyc = 1 + FRAME * 3 + 5;
    run_seq(64'h7, 8'h01, ncyc);
    check_frames(nf, 8'h01, "burst");
    chk("burst_idle_after", txs[1 + FRAME * nf + CPB / 2], 1);
    chk("burst_overflow", ovfs[ncyc - 1], (CAP + 1 < 3));

    // Six pushes back to back: CAP+1 sent, the rest dropped.
    reset_pulse();
    nf   = CAP + 1;
    ncyc = 1 + FRAME * 5 + 8;
    run_seq(64'h3F, 8'h11, ncyc);
    chk("ovf_full_flag", fulls[CAP], 1);
    chk("ovf_before_drop", ovfs[CAP], 0);
    chk("ovf_after_drop", ovfs[CAP + 1], 1);
    check_frames(nf, 8'h11, "ovf");
    chk("ovf_idle_after", txs[1 + FRAME * nf + CPB / 2], 1);

    // Push while full, coinciding with the pop at the end of the first frame.
    reset_pulse();
    m = '0;
    for (int i = 0; i <= CAP; i++) m[i] = 1'b1;
    m[41] = 1'b1;
    nf   = CAP + 2;
    ncyc = 1 + FRAME * nf + 4;
    run_seq(m, 8'h30, ncyc);
    chk("fullpop_full_before", fulls[40], 1);
    chk("fullpop_overflow", ovfs[ncyc - 1], 0);
    check_frames(nf, 8'h30, "fullpop");

    // Reset during data bit 3 of a 0x00 frame with another byte waiting.
    reset_pulse();
    run_seq(64'h3, 8'h00, 19);
    chk("midrst_tx_low_before", txs[18], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_TX", TX, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_full", full, 0);
    chk("midrst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_seq(64'h1, 8'h3C, 45);
    check_frames(1, 8'h3C, "postrst");
    chk("postrst_busy_release", first_idle(45), 41);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
